// File: rtl/max_unpool_pkg.sv
// max_unpool_pkg: window positions, sequencer states and buffer entry sizing
package max_unpool_pkg;
  localparam logic [1:0] POS_TL = 2'd0;
  localparam logic [1:0] POS_TR = 2'd1;
  localparam logic [1:0] POS_BL = 2'd2;
  localparam logic [1:0] POS_BR = 2'd3;
  localparam int IDX_W = 2;
  typedef enum logic {TOP, BOT} state_t;
  function automatic int entry_w(input int bitwidth);
    return bitwidth + IDX_W;
  endfunction
endpackage

// File: rtl/unpool_row_buf.sv
// unpool_row_buf: one pooled row of {idx,value} entries, sync write / async read
module unpool_row_buf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 10,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/max_unpool.sv
// max_unpool: streaming 2x2 max-unpooling, upper row emitted live, lower row replayed from the row buffer
module max_unpool
  import max_unpool_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int IN_WIDTH = 14,
  parameter int IN_HEIGHT = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BITWIDTH-1:0] in_data,
  input  logic [1:0]                 in_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [BITWIDTH-1:0] out_data,
  output logic                       out_last
);
  localparam int EW = entry_w(BITWIDTH);
  localparam int CW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
  localparam int RW = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
  localparam logic [CW-1:0] col_last = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] row_last = RW'(IN_HEIGHT - 1);
  state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic phase, slot_free, accept, beat;
  logic [EW-1:0] wreg, rd, src;
  logic [1:0] pos;
  assign slot_free = !out_valid || out_ready;
  assign in_ready = rst_n && state == TOP && !phase && slot_free;
  assign accept = in_valid && in_ready;
  assign beat = slot_free && (state == BOT || phase || in_valid);
  // phase 0 of the upper row uses the incoming element directly for 1-cycle latency
  assign src = state == BOT ? rd : phase ? wreg : {in_idx, in_data};
  assign pos = state == TOP ? (phase ? POS_TR : POS_TL) : (phase ? POS_BR : POS_BL);
  unpool_row_buf #(.DEPTH(IN_WIDTH), .WIDTH(EW), .AW(CW)) u_buf (
    .clk(clk),
    .we(accept),
    .waddr(col),
    .wdata({in_idx, in_data}),
    .raddr(col),
    .rdata(rd)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= TOP;
      col <= '0;
      row <= '0;
      phase <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (beat) begin
      out_valid <= 1'b1;
      out_data <= src[EW-1 -: 2] == pos ? src[BITWIDTH-1:0] : '0;
      out_last <= state == BOT && phase && col == col_last && row == row_last;
      phase <= !phase;
      if (accept) wreg <= {in_idx, in_data};
      if (phase) begin
        col <= col == col_last ? '0 : col + 1'b1;
        if (col == col_last) begin
          state <= state == TOP ? BOT : TOP;
          if (state == BOT) row <= row == row_last ? '0 : row + 1'b1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_max_unpool.sv
// tb_max_unpool: table-driven frames through a 2x2-pooled-map unpooler with bubbles, stalls and reset
module tb_max_unpool;
  localparam int W = 2, H = 2, NI = W * H, N = 4 * W * H;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last;
  logic signed [7:0] in_data = '0, out_data;
  logic [1:0] in_idx = '0;
  int checks = 0, fails = 0;
  typedef struct {int d; int i;} in_t;
  in_t fin[2][NI];
  int fexp[2][N];

  max_unpool #(.BITWIDTH(8), .IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_idx(in_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // mode bit0: in_valid bubbles, bit1: out_ready low for 3 cycles mid lower row
  task automatic frame(input int v, input int mode, input int stop_in);
    int ip = 0, op = 0, loaded, held_d = 0;
    bit held = 0;
    for (int cyc = 0; cyc < 300 && op < N && ip != stop_in; cyc++) begin
      @(negedge clk);
      in_valid = ip < NI && ((mode & 1) == 0 || cyc % 4 == 0 || cyc % 4 == 3);
      if (ip < NI) begin
        in_data = 8'(fin[v][ip].d);
        in_idx = 2'(fin[v][ip].i);
      end
      out_ready = !((mode & 2) != 0 && cyc >= 6 && cyc < 9);
      #1;
      if (held) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), held_d);
      end
      loaded = op + int'(out_valid);
      chk($sformatf("in_ready@%0d", loaded), int'(in_ready),
          int'(loaded % (4 * W) < 2 * W && loaded % 2 == 0 && (!out_valid || out_ready)));
      if (out_valid && out_ready) begin
        chk($sformatf("f%0d_data[%0d]", v, op), int'(out_data), fexp[v][op]);
        chk($sformatf("f%0d_last[%0d]", v, op), int'(out_last), int'(op == N - 1));
        op++;
      end
      held = out_valid && !out_ready;
      held_d = int'(out_data);
      if (in_valid && in_ready) ip++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (stop_in < 0) begin
      chk("beats", op, N);
      #1;
      chk("idle_valid", int'(out_valid), 0);
    end
  endtask

  initial begin
    fin[0] = '{'{1, 0}, '{2, 1}, '{3, 2}, '{4, 3}};
    fexp[0] = '{1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 4};
    fin[1] = '{'{-128, 1}, '{127, 2}, '{5, 0}, '{-3, 3}};
    fexp[1] = '{0, -128, 0, 0, 0, 0, 127, 0, 5, 0, 0, 0, 0, 0, 0, -3};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    frame(0, 0, -1);
    frame(0, 2, -1);
    frame(1, 1, -1);
    frame(0, 0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_last", int'(out_last), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    frame(1, 3, -1);
    frame(0, 0, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/max_unpool.md
Name: max_unpool

Overview:
- Streaming 2x2 max-unpooling block, the inverse of the 2x2 max-pool stage.
- Accepts pooled feature-map elements in raster order, each with a 2-bit argmax position index.
- Emits the upsampled map (2*IN_WIDTH x 2*IN_HEIGHT) in raster order.
  - Each pooled value is placed at its recorded window position.
  - The other three positions are 0.
- Sits between pool-index storage and the backward/reconstruction datapath.
- Valid/ready on both sides.

Parameters:
- BITWIDTH, 8, signed element width
- IN_WIDTH, 14, pooled elements per row
- IN_HEIGHT, 14, pooled rows per frame

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  pooled element valid
- in_ready  output  1  block can accept element
- in_data  input  BITWIDTH  signed pooled value
- in_idx  input  2  window position of max: 0=TL(a), 1=TR(b), 2=BL(c), 3=BR(d)
- out_valid  output  1  output element valid
- out_ready  input  1  downstream accepts
- out_data  output  BITWIDTH  signed upsampled element
- out_last  output  1  high on final element of frame

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset (rst_n=0 at posedge):
  - state=TOP, col=0, row=0, phase=0.
  - out_valid=0, out_data=0, out_last=0, in_ready=0 during reset.
  - Line buffer contents are not reset (don't care).
- Output register:
  - Advances when !out_valid || out_ready (call this "slot free").
  - If out_valid && !out_ready, out_data and out_last hold stable.
- State TOP (emit upper output row, capture buffer):
  - in_ready = slot free && phase==0.
  - On accept:
    - Write {in_idx,in_data} to buffer[col] and to a working register.
    - Next cycle: out_data = (idx==0)?v:0, out_valid=1, phase=1.
  - Phase 1, when slot free: out_data = (idx==1)?v:0, phase=0.
    - If col==IN_WIDTH-1: col=0, state=BOT; else col++.
  - Input-to-output latency: 1 cycle.
  - Maximum input rate: 1 element per 2 cycles.
- State BOT (emit lower output row from buffer):
  - in_ready=0.
  - Per column: phase 0 emits (idx==2)?v:0; phase 1 emits (idx==3)?v:0.
  - Both phases use buffer[col], one beat per cycle when slot free.
  - After phase 1 of col IN_WIDTH-1:
    - col=0, state=TOP.
    - If row==IN_HEIGHT-1, row=0 (frame wrap); else row++.
- out_last=1 only on BOT, row==IN_HEIGHT-1, col==IN_WIDTH-1, phase 1 beat.
- in_valid low in TOP: no output is generated and the state holds. Bubbles are legal on both sides.
- Simultaneous events:
  - Input acceptance and output drain in the same cycle are legal in TOP phase 0: the previous beat is consumed while the new one loads.
  - out_ready held low stalls everything without loss.
- Mid-frame reset: abandons the frame and restarts at row 0 col 0. No partial output follows reset.
- Output count per frame is exactly 4*IN_WIDTH*IN_HEIGHT.
- Value rules:
  - Values pass unmodified (no width change).
  - Negative values are preserved.
  - Zero fill is signed 0.
- Index ordering matches the forward pool's a,b,c,d operand order. Ties are resolved upstream, so the block trusts in_idx.

Decomposition:
- Package max_unpool_pkg:
  - position constants POS_TL=0, POS_TR=1, POS_BL=2, POS_BR=3
  - state enum {TOP, BOT}
  - buffer entry width BITWIDTH+2
- One sub-module: unpool_row_buf.
  - IN_WIDTH x (BITWIDTH+2) storage.
  - Synchronous write, asynchronous read (distributed RAM/registers).
  - One write port, one read port.

Test Plan:
- IN_WIDTH=2, IN_HEIGHT=1; inputs (5,idx0),(-3,idx3); out_ready=1 -> output sequence 5,0,0,0 / 0,0,0,-3; out_last on 8th beat only.
- IN_WIDTH=2, IN_HEIGHT=2; inputs (1,0),(2,1),(3,2),(4,3) -> 1,0,0,2 / 0,0,0,0 / 0,0,0,0 / 3,0,0,4; out_last on 16th beat only; a second frame restarts identically.
- Backpressure: out_ready low for 3 cycles mid-BOT -> out_data/out_valid held, no beat dropped or duplicated, in_ready=0 throughout BOT.
- Input bubbles: in_valid toggling 1,0,0,1 in TOP -> output order unchanged, no spurious out_valid during gaps.
- Reset mid-frame (after 3 inputs): rst_n=0 one cycle -> out_valid=0 next cycle; subsequent frame output starts fresh at row 0 col 0 with correct out_last placement.
- Extremes (BITWIDTH=8): value -128 with idx 1, value 127 with idx 2 -> values appear exactly at TR / BL positions, all others 0.
